// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer drawing engine and the VGA driver:
// default resolution/address width, command opcodes and the engine state type.
package fb_pkg;

  localparam int FB_H_RES   = 160;
  localparam int FB_V_RES   = 120;
  localparam int FB_ADDR_W  = 15;
  localparam int FB_COLOR_W = 24;

  localparam logic OP_FILL_RECT = 1'b0;
  localparam logic OP_END_FRAME = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Row-major pixel address walker: column/row counters, incremental row base
// and address registers, and a last-pixel flag. Row base uses a constant shift-add.
module fb_addr_gen #(
  parameter int H_RES  = 160,
  parameter int ADDR_W = 15,
  parameter int DIM_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [7:0]        i_x,
  input  logic [7:0]        i_y,
  input  logic [DIM_W-1:0]  i_w,
  input  logic [DIM_W-1:0]  i_h,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [31:0]       LP_HMUL  = 32'(H_RES);
  localparam logic [ADDR_W-1:0] LP_HSTEP = ADDR_W'(H_RES);
  localparam logic [DIM_W-1:0]  LP_ONE   = DIM_W'(1);

  logic [7:0]        r_x;
  logic [DIM_W-1:0]  r_w;
  logic [DIM_W-1:0]  r_h;
  logic [DIM_W-1:0]  r_col;
  logic [DIM_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_base;

  // y*H_RES as a sum of shifted copies of y; H_RES is constant so this folds to adders.
  always_comb begin
    w_base = '0;
    for (int i = 0; i < 32; i++) begin
      if (LP_HMUL[i]) w_base = w_base + (ADDR_W'(i_y) << i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (i_start) begin
      r_x        <= i_x;
      r_w        <= i_w;
      r_h        <= i_h;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= w_base;
      r_addr     <= w_base + ADDR_W'(i_x);
    end else if (i_step) begin
      if (r_col == r_w - LP_ONE) begin
        r_col      <= '0;
        r_row      <= r_row + LP_ONE;
        r_row_base <= r_row_base + LP_HSTEP;
        r_addr     <= r_row_base + LP_HSTEP + ADDR_W'(r_x);
      end else begin
        r_col  <= r_col + LP_ONE;
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_col == r_w - LP_ONE) && (r_row == r_h - LP_ONE);

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill / end-of-frame drawing engine writing one pixel per clock into
// the back buffer. Define RECT_FILL_CLIP_EN to clip rectangles instead of rejecting them.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int H_RES   = FB_H_RES,
  parameter int V_RES   = FB_V_RES,
  parameter int COLOR_W = FB_COLOR_W,
  parameter int ADDR_W  = FB_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [7:0]         cmd_x,
  input  logic [7:0]         cmd_y,
  input  logic [7:0]         cmd_w,
  input  logic [7:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               fb_wr_en,
  output logic [ADDR_W-1:0]  fb_wr_addr,
  output logic [COLOR_W-1:0] fb_wr_data,
  output logic               swap_req,
  input  logic               swap_ack,
  output logic               busy,
  output logic               err
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is only ever high in IDLE, so at most one command is in flight.

  localparam int DIM_W = 9;
  localparam logic [DIM_W-1:0] LP_H = DIM_W'(H_RES);
  localparam logic [DIM_W-1:0] LP_V = DIM_W'(V_RES);

  fb_state_e          r_state;
  logic               r_cmd_ready;
  logic               r_wr_en;
  logic [COLOR_W-1:0] r_wr_data;
  logic               r_swap_req;
  logic               r_busy;
  logic               r_err;

  logic [DIM_W-1:0]   w_x_end;
  logic [DIM_W-1:0]   w_y_end;
  logic [DIM_W-1:0]   w_eff_w;
  logic [DIM_W-1:0]   w_eff_h;
  logic               w_reject;
  logic               w_zero;
  logic               w_hs;
  logic               w_start;
  logic               w_step;
  logic               w_last;
  logic [ADDR_W-1:0]  w_addr;

  assign w_x_end = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign w_y_end = {1'b0, cmd_y} + {1'b0, cmd_h};

  always_comb begin
    w_eff_w  = {1'b0, cmd_w};
    w_eff_h  = {1'b0, cmd_h};
    w_reject = 1'b0;
`ifdef RECT_FILL_CLIP_EN
    if ({1'b0, cmd_x} >= LP_H)  w_eff_w = '0;
    else if (w_x_end > LP_H)    w_eff_w = LP_H - {1'b0, cmd_x};
    if ({1'b0, cmd_y} >= LP_V)  w_eff_h = '0;
    else if (w_y_end > LP_V)    w_eff_h = LP_V - {1'b0, cmd_y};
`else
    w_reject = (w_x_end > LP_H) || (w_y_end > LP_V);
`endif
  end

  assign w_zero  = (w_eff_w == '0) || (w_eff_h == '0);
  assign w_hs    = (r_state == IDLE) && cmd_valid && r_cmd_ready;
  assign w_start = w_hs && (cmd_op == OP_FILL_RECT) && !w_reject && !w_zero;
  assign w_step  = (r_state == FILL) && r_wr_en && !w_last;

  fb_addr_gen #(
    .H_RES (H_RES),
    .ADDR_W(ADDR_W),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_step (w_step),
    .i_x    (cmd_x),
    .i_y    (cmd_y),
    .i_w    (w_eff_w),
    .i_h    (w_eff_h),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_swap_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_op == OP_END_FRAME) begin
              r_state    <= SWAP_WAIT;
              r_swap_req <= 1'b1;
            end else begin
              // Rejected and zero-area commands still spend one cycle in FILL.
              r_state   <= FILL;
              r_wr_data <= cmd_color;
              r_wr_en   <= !w_reject && !w_zero;
              r_err     <= w_reject;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        FILL: begin
          if (!r_wr_en || w_last) begin
            r_wr_en     <= 1'b0;
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        SWAP_WAIT: begin
          if (swap_ack) begin
            r_swap_req  <= 1'b0;
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign fb_wr_en   = r_wr_en;
  assign fb_wr_addr = w_addr;
  assign fb_wr_data = r_wr_data;
  assign swap_req   = r_swap_req;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: pixel-list reference model feeding an expected-write
// queue, drained by an independent monitor on the falling edge.
module tb_fb_rect_writer;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int AW = 15;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [7:0]    cmd_x, cmd_y, cmd_w, cmd_h;
  logic [CW-1:0] cmd_color;
  logic          fb_wr_en;
  logic [AW-1:0] fb_wr_addr;
  logic [CW-1:0] fb_wr_data;
  logic          swap_req;
  logic          swap_ack;
  logic          busy;
  logic          err;

  fb_rect_writer #(.H_RES(H), .V_RES(V), .COLOR_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int exp_err_total = 0;
  time t_last_wr = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [AW+CW-1:0] exp_q[$];
  logic [AW+CW-1:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (err) err_seen++;
    if (fb_wr_en) begin
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_write addr=%0d data=%0h", fb_wr_addr, fb_wr_data));
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(fb_wr_addr), 64'(mon_e[AW+CW-1:CW]));
        chk("wr_data", 64'(fb_wr_data), 64'(mon_e[CW-1:0]));
      end
      t_last_wr    = $time;
      last_wr_addr = fb_wr_addr;
    end
  end

  // reference model: enumerate the rectangle's pixels directly
  task automatic model_fill(input int x, input int y, input int w, input int h,
                            input logic [CW-1:0] col, output int np, output bit rej);
    np = 0;
`ifdef RECT_FILL_CLIP_EN
    rej = 1'b0;
`else
    rej = (x + w > H) || (y + h > V);
`endif
    if (!rej) begin
      for (int r = y; r < y + h; r++) begin
        for (int c = x; c < x + w; c++) begin
          if (c < H && r < V) begin
            exp_q.push_back({AW'(r * H + c), col});
            np++;
          end
        end
      end
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
  endtask

  task automatic scramble_inputs();
    cmd_op    = 1'($urandom_range(0, 1));
    cmd_x     = 8'($urandom);
    cmd_y     = 8'($urandom);
    cmd_w     = 8'($urandom);
    cmd_h     = 8'($urandom);
    cmd_color = CW'($urandom);
  endtask

  task automatic send_fill(input int x, input int y, input int w, input int h, input logic [CW-1:0] col);
    int np;
    bit rej;
    int low;
    wait_ready();
    model_fill(x, y, w, h, col, np, rej);
    if (rej) exp_err_total++;
    cmd_op = 1'b0; cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h); cmd_color = col;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble_inputs();
    @(negedge clk);
    chk("err_at_n1", 64'(err), 64'(rej));
    chk("busy_at_n1", 64'(busy), 64'd1);
    low = 0;
    while (!cmd_ready && low < 30000) begin
      low++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 64'(low), 64'((np == 0) ? 1 : np));
  endtask

  task automatic send_end(input int delay);
    wait_ready();
    cmd_op = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    scramble_inputs();
    cmd_op = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("swap_req_held", 64'(swap_req), 64'd1);
      chk("ready_low_in_swap", 64'(cmd_ready), 64'd0);
      if (i == delay - 1) begin
        swap_ack  = 1'b1;
        cmd_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    swap_ack = 1'b0;
    @(negedge clk);
    chk("swap_req_dropped", 64'(swap_req), 64'd0);
    chk("ready_after_ack", 64'(cmd_ready), 64'd1);
    chk("busy_after_ack", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_fb_wr_en", 64'(fb_wr_en), 64'd0);
    chk("rst_fb_wr_addr", 64'(fb_wr_addr), 64'd0);
    chk("rst_fb_wr_data", 64'(fb_wr_data), 64'd0);
    chk("rst_swap_req", 64'(swap_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
  endtask

  task automatic reset_mid_fill();
    int np;
    bit rej;
    logic [AW+CW-1:0] keep;
    wait_ready();
    model_fill(5, 5, 10, 10, 24'h00FF00, np, rej);
    cmd_op = 1'b0; cmd_x = 8'd5; cmd_y = 8'd5; cmd_w = 8'd10; cmd_h = 8'd10; cmd_color = 24'h00FF00;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    // third pixel is on the bus now; everything after it is aborted
    rst = 1'b0;
    keep = exp_q[0];
    exp_q.delete();
    exp_q.push_back(keep);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    chk("queue_empty_after_rst", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("ready_after_rst_release", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    swap_ack = 1'b0;
    cmd_op = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_still_low", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_rises", 64'(cmd_ready), 64'd1);

    send_fill(2, 3, 4, 2, 24'hFF0000);
    send_fill(10, 10, 0, 5, 24'h123456);
    send_fill(158, 0, 4, 1, 24'h0000FF);
    send_fill(200, 50, 5, 5, 24'hABCDEF);

    // stray ack while idle
    swap_ack = 1'b1;
    @(posedge clk);
    #1;
    swap_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_swap_req", 64'(swap_req), 64'd0);
    chk("stray_ack_busy", 64'(busy), 64'd0);
    chk("stray_ack_ready", 64'(cmd_ready), 64'd1);

    send_end(100);
    send_end(1);
    reset_mid_fill();
    send_fill(1, 1, 3, 3, 24'h777777);

    send_fill(0, 0, 160, 120, 24'h010203);
    chk("fullscreen_last_addr", 64'(last_wr_addr), 64'd19199);
    chk("b2b_gap", 64'($time - t_last_wr), 64'd10);
    send_fill(0, 0, 160, 120, 24'h040506);
    chk("fullscreen2_last_addr", 64'(last_wr_addr), 64'd19199);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0)
        send_end($urandom_range(1, 6));
      else
        send_fill($urandom_range(0, 165), $urandom_range(0, 125), $urandom_range(0, 12),
                  $urandom_range(0, 12), CW'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("err_pulse_count", 64'(err_seen), 64'(exp_err_total));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
